// File: rtl/mbus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mbus_pkg : mbus command fields, data-command codes and responder states   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package mbus_pkg;

  localparam int CMD_DATA      = 4;
  localparam int CMD_WRITE     = 3;
  localparam int CMD_BLOCK     = 2;
  localparam int CMD_SIZE_HI   = 1;
  localparam int CMD_SIZE_LO   = 0;
  localparam int DCMD_NEXT_BIT = 3;

  localparam logic [1:0] SIZE_2W  = 2'b00;
  localparam logic [1:0] SIZE_4W  = 2'b01;
  localparam logic [1:0] SIZE_8W  = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;

  localparam logic [4:0] NEXT = 5'b11000;
  localparam logic [4:0] LAST = 5'b10000;

  typedef enum logic [2:0] {
    S_RECOVER = 3'd0,
    S_GRANT   = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_DATA = 3'd3,
    S_WR_DATA = 3'd4
  } state_t;

  // Zero marks the illegal size encoding.
  function automatic logic [3:0] size_words(input logic [1:0] size);
    case (size)
      SIZE_2W: return 4'd2;
      SIZE_4W: return 4'd4;
      SIZE_8W: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbus_mem.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mbus_mem : synchronous-write, registered-read 32-bit word memory          |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module mbus_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/mbus_resp.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mbus_resp : RCP-side mbus bus-functional responder with backing memory    |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mbus_resp
  import mbus_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int READ_LAT  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p_valid_l,
  input  logic [31:0] sys_ad_in,
  input  logic [4:0]  sys_cmd_in,
  output logic        e_ok_l,
  output logic        e_valid_l,
  output logic [31:0] sys_ad_out,
  output logic [4:0]  sys_cmd_out,
  output logic        ad_oe,
  output logic        err
);

  localparam int c_AW = $clog2(MEM_WORDS);
  localparam int c_WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [c_WW-1:0] c_WAIT_INIT = c_WW'(READ_LAT - 1);
  localparam logic [c_WW-1:0] c_WAIT_ONE  = c_WW'(1);

  state_t            r_state, w_next;
  logic              r_ok_prev;
  logic [c_WW-1:0]   r_wait, w_next_wait;
  logic [3:0]        r_len, w_next_len;
  logic [2:0]        r_mask, w_next_mask;
  logic [2:0]        r_cnt, w_next_cnt;
  logic [3:0]        r_iss, w_next_iss;
  logic [c_AW-1:0]   r_addr, w_next_addr;
  logic              r_e_ok_l, r_e_valid_l, r_ad_oe, r_err;
  logic [31:0]       r_ad_out;
  logic [4:0]        r_cmd_out;

  logic              w_accept, w_cmd_bad, w_set_err, w_mem_we, w_final_out;
  logic              w_wr_final, w_wr_last, w_unused_ad;
  logic [3:0]        w_cmd_len;
  logic [2:0]        w_cmd_mask;
  logic [c_AW-1:0]   w_cmd_idx, w_mem_raddr;
  logic [31:0]       w_mem_rdata;

  // Next word address, wrapping inside the naturally aligned block.
  function automatic logic [c_AW-1:0] wrap_inc(input logic [c_AW-1:0] a, input logic [2:0] m);
    logic [c_AW-1:0] mm;
    mm = {{(c_AW-3){1'b0}}, m};
    return (a & ~mm) | ((a + {{(c_AW-1){1'b0}}, 1'b1}) & mm);
  endfunction

  assign w_unused_ad = ^{sys_ad_in[1:0], sys_ad_in[31:c_AW+2]};
  assign w_cmd_idx   = sys_ad_in[c_AW+1:2];
  assign w_cmd_len   = sys_cmd_in[CMD_BLOCK] ? size_words(sys_cmd_in[CMD_SIZE_HI:CMD_SIZE_LO]) : 4'd1;
  assign w_cmd_mask  = w_cmd_len[2:0] - 3'd1;
  assign w_cmd_bad   = sys_cmd_in[CMD_DATA] ||
                       (sys_cmd_in[CMD_BLOCK] && (sys_cmd_in[CMD_SIZE_HI:CMD_SIZE_LO] == SIZE_BAD));
  assign w_accept    = (r_state == S_GRANT) && !r_ok_prev && !p_valid_l;
  assign w_wr_final  = ({1'b0, r_cnt} == (r_len - 4'd1));
  assign w_wr_last   = !sys_cmd_in[DCMD_NEXT_BIT];
  assign w_final_out = ({1'b0, w_next_cnt} == (r_len - 4'd1));

  always_comb begin
    w_next      = r_state;
    w_next_wait = r_wait;
    w_next_len  = r_len;
    w_next_mask = r_mask;
    w_next_cnt  = r_cnt;
    w_next_iss  = r_iss;
    w_next_addr = r_addr;
    w_mem_raddr = r_addr;
    w_mem_we    = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_RECOVER: w_next = S_GRANT;
      S_GRANT: begin
        if (w_accept) begin
          if (w_cmd_bad) begin
            w_set_err = 1'b1;
            w_next    = S_RECOVER;
          end else begin
            w_next_len  = w_cmd_len;
            w_next_mask = w_cmd_mask;
            w_next_cnt  = 3'd0;
            w_next_iss  = 4'd0;
            w_next_addr = w_cmd_idx;
            if (sys_cmd_in[CMD_WRITE]) begin
              w_next = S_WR_DATA;
            end else begin
              w_next      = S_RD_WAIT;
              w_next_wait = c_WAIT_INIT;
              // Single-cycle latency needs the first read issued off the command itself.
              if (READ_LAT == 1) begin
                w_mem_raddr = w_cmd_idx;
                w_next_addr = wrap_inc(w_cmd_idx, w_cmd_mask);
                w_next_iss  = 4'd1;
              end
            end
          end
        end
      end
      S_RD_WAIT: begin
        if ((r_wait <= c_WAIT_ONE) && (r_iss < r_len)) begin
          w_next_addr = wrap_inc(r_addr, r_mask);
          w_next_iss  = r_iss + 4'd1;
        end
        if (r_wait == '0) begin
          w_next     = S_RD_DATA;
          w_next_cnt = 3'd0;
        end else begin
          w_next_wait = r_wait - c_WAIT_ONE;
        end
      end
      S_RD_DATA: begin
        if (r_iss < r_len) begin
          w_next_addr = wrap_inc(r_addr, r_mask);
          w_next_iss  = r_iss + 4'd1;
        end
        if (w_wr_final) begin
          w_next = S_RECOVER;
        end else begin
          w_next_cnt = r_cnt + 3'd1;
        end
      end
      S_WR_DATA: begin
        if (p_valid_l || !sys_cmd_in[CMD_DATA] || (w_wr_final != w_wr_last)) begin
          w_set_err = 1'b1;
          w_next    = S_RECOVER;
        end else begin
          w_mem_we = 1'b1;
          if (w_wr_final) begin
            w_next = S_RECOVER;
          end else begin
            w_next_cnt  = r_cnt + 3'd1;
            w_next_addr = wrap_inc(r_addr, r_mask);
          end
        end
      end
      default: w_next = S_RECOVER;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RECOVER;
      r_ok_prev   <= 1'b1;
      r_wait      <= '0;
      r_len       <= 4'd0;
      r_mask      <= 3'd0;
      r_cnt       <= 3'd0;
      r_iss       <= 4'd0;
      r_addr      <= '0;
      r_e_ok_l    <= 1'b1;
      r_e_valid_l <= 1'b1;
      r_ad_oe     <= 1'b0;
      r_ad_out    <= '0;
      r_cmd_out   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ok_prev   <= r_e_ok_l;
      r_wait      <= w_next_wait;
      r_len       <= w_next_len;
      r_mask      <= w_next_mask;
      r_cnt       <= w_next_cnt;
      r_iss       <= w_next_iss;
      r_addr      <= w_next_addr;
      r_e_ok_l    <= (w_next != S_GRANT);
      r_e_valid_l <= (w_next != S_RD_DATA);
      r_ad_oe     <= (w_next == S_RD_DATA);
      r_ad_out    <= (w_next == S_RD_DATA) ? w_mem_rdata : 32'd0;
      r_cmd_out   <= (w_next == S_RD_DATA) ? (w_final_out ? LAST : NEXT) : 5'd0;
      r_err       <= r_err | w_set_err;
    end
  end

  mbus_mem #(
    .DEPTH (MEM_WORDS),
    .AW    (c_AW)
  ) u_mem (
    .clk     (clock),
    .i_we    (w_mem_we),
    .i_waddr (r_addr),
    .i_wdata (sys_ad_in),
    .i_raddr (w_mem_raddr),
    .o_rdata (w_mem_rdata)
  );

  assign e_ok_l      = r_e_ok_l;
  assign e_valid_l   = r_e_valid_l;
  assign sys_ad_out  = r_ad_out;
  assign sys_cmd_out = r_cmd_out;
  assign ad_oe       = r_ad_oe;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mbus_resp.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mbus_resp : processor-side stimulus and scoreboard for mbus_resp       |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_mbus_resp;

  localparam int MEM_WORDS = 1024;
  localparam int READ_LAT  = 3;
  localparam int AW        = $clog2(MEM_WORDS);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p_valid_l = 1'b1;
  logic [31:0] sys_ad_in = '0;
  logic [4:0]  sys_cmd_in = '0;
  logic        e_ok_l, e_valid_l, ad_oe, err;
  logic [31:0] sys_ad_out;
  logic [4:0]  sys_cmd_out;

  mbus_resp #(.MEM_WORDS(MEM_WORDS), .READ_LAT(READ_LAT)) dut (
    .clock(clock), .reset(reset), .p_valid_l(p_valid_l), .sys_ad_in(sys_ad_in),
    .sys_cmd_in(sys_cmd_in), .e_ok_l(e_ok_l), .e_valid_l(e_valid_l),
    .sys_ad_out(sys_ad_out), .sys_cmd_out(sys_cmd_out), .ad_oe(ad_oe), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  cmd;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [MEM_WORDS];
  beat_t       exp_q [$];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; p_valid_l = 1'b1; sys_cmd_in = '0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  function automatic int blen(input logic [4:0] cmd);
    return cmd[2] ? (2 << cmd[1:0]) : 1;
  endfunction

  function automatic int waddr(input logic [31:0] a, input int len, input int j);
    int idx, base;
    idx  = int'(a[AW+1:2]);
    base = idx & ~(len - 1);
    return base | ((idx + j) & (len - 1));
  endfunction

  task automatic push_expected(input logic [4:0] cmd, input logic [31:0] addr);
    int len;
    beat_t b;
    len = blen(cmd);
    for (int j = 0; j < len; j++) begin
      b.data = model[waddr(addr, len, j)];
      b.cmd  = (j == len - 1) ? 5'b10000 : 5'b11000;
      exp_q.push_back(b);
    end
  endtask

  // Processor rule: drive a command only after e_ok_l was low two cycles running.
  task automatic issue_cmd(input logic [4:0] cmd, input logic [31:0] addr);
    int run = 0;
    for (int i = 0; i < 32; i++) begin
      if (e_ok_l === 1'b0) run++; else run = 0;
      if (run >= 2) break;
      cyc();
    end
    if (run < 2) begin
      checks++; errors++;
      $display("FAIL grant_timeout e_ok_l=%b never low two cycles", e_ok_l);
    end
    p_valid_l = 1'b0; sys_cmd_in = cmd; sys_ad_in = addr;
  endtask

  // Entered just after the command-sample edge.
  task automatic collect();
    int t = 0;
    beat_t b;
    while (e_valid_l !== 1'b0 && t < 40) begin cyc(); t++; end
    checks++;
    if (t != READ_LAT) begin
      errors++;
      $display("FAIL read_latency got %0d cycles want %0d", t, READ_LAT);
    end
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      checks++;
      if ({e_valid_l, ad_oe, sys_ad_out, sys_cmd_out} !== {1'b0, 1'b1, b.data, b.cmd}) begin
        errors++;
        $display("FAIL read_beat got v_l=%b oe=%b data=%h cmd=%b want v_l=0 oe=1 data=%h cmd=%b",
                 e_valid_l, ad_oe, sys_ad_out, sys_cmd_out, b.data, b.cmd);
      end
      cyc();
    end
    checks++;
    if (e_valid_l !== 1'b1 || ad_oe !== 1'b0) begin
      errors++;
      $display("FAIL read_end got v_l=%b oe=%b want v_l=1 oe=0", e_valid_l, ad_oe);
    end
  endtask

  task automatic wr(input logic [4:0] cmd, input logic [31:0] addr, input logic [31:0] d [8]);
    int len;
    len = blen(cmd);
    issue_cmd(cmd, addr);
    for (int j = 0; j < len; j++) begin
      cyc();
      sys_ad_in  = d[j];
      sys_cmd_in = (j == len - 1) ? 5'b10000 : 5'b11000;
      model[waddr(addr, len, j)] = d[j];
    end
    cyc();
    p_valid_l = 1'b1; sys_cmd_in = '0;
  endtask

  task automatic rd(input logic [4:0] cmd, input logic [31:0] addr);
    push_expected(cmd, addr);
    issue_cmd(cmd, addr);
    cyc();
    p_valid_l = 1'b1; sys_cmd_in = '0;
    collect();
  endtask

  task automatic test_reset();
    checks++; if (e_ok_l !== 1'b1) begin errors++; $display("FAIL rst_e_ok_l got %b want 1", e_ok_l); end
    checks++; if (e_valid_l !== 1'b1) begin errors++; $display("FAIL rst_e_valid_l got %b want 1", e_valid_l); end
    checks++; if (ad_oe !== 1'b0) begin errors++; $display("FAIL rst_ad_oe got %b want 0", ad_oe); end
    checks++; if (sys_ad_out !== 32'd0) begin errors++; $display("FAIL rst_sys_ad_out got %h want 0", sys_ad_out); end
    checks++; if (sys_cmd_out !== 5'd0) begin errors++; $display("FAIL rst_sys_cmd_out got %b want 0", sys_cmd_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
  endtask

  task automatic test_word();
    logic [31:0] d [8];
    d = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
    wr(5'b01000, 32'h100, d);
    rd(5'b00000, 32'h100);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL word_err got %b want 0", err); end
  endtask

  task automatic test_block_wrap();
    logic [31:0] d [8];
    d = '{1, 2, 3, 4, 0, 0, 0, 0};
    wr(5'b01101, 32'h208, d);
    rd(5'b00101, 32'h200);
  endtask

  task automatic test_block8();
    logic [31:0] d [8];
    for (int j = 0; j < 8; j++) d[j] = 32'hA0 + j;
    wr(5'b01110, 32'h314, d);
    rd(5'b00110, 32'h300);
    rd(5'b00100, 32'h31C);
  endtask

  task automatic test_early_grant();
    reset = 1'b1; cyc(); cyc();
    reset = 1'b0; p_valid_l = 1'b0; sys_cmd_in = 5'b00000; sys_ad_in = 32'h100;
    push_expected(5'b00000, 32'h100);
    cyc();
    checks++; if (e_ok_l !== 1'b0) begin errors++; $display("FAIL early_grant1 e_ok_l got %b want 0", e_ok_l); end
    cyc();
    checks++; if (e_ok_l !== 1'b0) begin errors++; $display("FAIL early_ignored e_ok_l got %b want 0", e_ok_l); end
    cyc();
    checks++; if (e_ok_l !== 1'b1) begin errors++; $display("FAIL early_accept e_ok_l got %b want 1", e_ok_l); end
    p_valid_l = 1'b1;
    collect();
  endtask

  task automatic test_early_last();
    issue_cmd(5'b01100, 32'h500);
    cyc();
    sys_ad_in = 32'h55; sys_cmd_in = 5'b10000;
    cyc();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_last_err got %b want 1", err); end
    checks++; if (e_ok_l !== 1'b1) begin errors++; $display("FAIL early_last_recover e_ok_l got %b want 1", e_ok_l); end
    p_valid_l = 1'b1; sys_cmd_in = '0;
    cyc();
    checks++; if (e_ok_l !== 1'b0) begin errors++; $display("FAIL early_last_grant e_ok_l got %b want 0", e_ok_l); end
  endtask

  task automatic test_bad_cmd(input logic [4:0] cmd);
    logic saw;
    do_reset();
    issue_cmd(cmd, 32'h300);
    cyc();
    p_valid_l = 1'b1; sys_cmd_in = '0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_cmd_err cmd=%b got %b want 1", cmd, err); end
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (e_valid_l !== 1'b1 || ad_oe !== 1'b0) saw = 1'b1;
      cyc();
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL bad_cmd_data cmd=%b data phase seen=%b want 0", cmd, saw); end
  endtask

  task automatic test_wr_gap();
    do_reset();
    issue_cmd(5'b01101, 32'h600);
    cyc();
    p_valid_l = 1'b1; sys_cmd_in = '0;
    cyc();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wr_gap_err got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d [8];
    int t = 0;
    do_reset();
    for (int j = 0; j < 8; j++) d[j] = 32'hB000_0000 + 32'(j * 17);
    wr(5'b01110, 32'h700, d);
    issue_cmd(5'b00110, 32'h700);
    cyc();
    p_valid_l = 1'b1; sys_cmd_in = '0;
    while (e_valid_l !== 1'b0 && t < 40) begin cyc(); t++; end
    cyc(); cyc();
    checks++; if (e_valid_l !== 1'b0) begin errors++; $display("FAIL mid_read_active e_valid_l got %b want 0", e_valid_l); end
    reset = 1'b1;
    cyc();
    checks++;
    if ({e_ok_l, e_valid_l, ad_oe, sys_ad_out, sys_cmd_out, err} !== {1'b1, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got ok_l=%b v_l=%b oe=%b data=%h cmd=%b err=%b want 1 1 0 0 0 0",
               e_ok_l, e_valid_l, ad_oe, sys_ad_out, sys_cmd_out, err);
    end
    reset = 1'b0;
    rd(5'b00110, 32'h700);
    rd(5'b00000, 32'h100);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    test_word();
    test_block_wrap();
    test_block8();
    test_early_grant();
    test_early_last();
    test_bad_cmd(5'b10000);
    test_bad_cmd(5'b00111);
    rd(5'b00000, 32'h100);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    test_wr_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mbus_resp.md
# mbus_resp

Bus-functional responder for the mbus, the processor-to-RCP system bus carrying `sys_ad`/`sys_cmd` under `p_valid_l`/`e_valid_l`/`e_ok_l`. It sits on the RCP side in simulation and test benches. It grants the bus and accepts processor commands. It backs reads and writes with an internal word memory and returns read data with the correct next/last data-command encoding. Protocol violations raise a sticky error flag instead of hanging the bus.

## Interface
- `MEM_WORDS`, default 1024: depth of the backing memory in 32-bit words (power of two).
- `READ_LAT`, default 3: cycles from command-cycle sample to first read data, at least 1.
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `p_valid_l` in 1: processor drives a valid command or data cycle (active low).
- `sys_ad_in` in 32: address in command cycles, write data in data cycles.
- `sys_cmd_in` in 5: command or data-command from the processor.
- `e_ok_l` out 1: responder ready to accept a command (active low).
- `e_valid_l` out 1: responder drives valid read data (active low).
- `sys_ad_out` out 32: read data.
- `sys_cmd_out` out 5: read data-command.
- `ad_oe` out 1: responder owns `sys_ad`/`sys_cmd` this cycle; tri-state enable for the bench.
- `err` out 1: sticky protocol-error flag, cleared only by `reset`.

## Operation
- Command field decode is `{data, write, block, size[1:0]}` = `sys_cmd_in[4:0]`.
- Data-command encoding is bit4=1. Bit3=1 means "next", bit3=0 means "last", and bits[2:0]=0 when driven.
- Block length is 2 words for size 00, 4 for 01, and 8 for 10. Size 11 is illegal. Word operations transfer 1 word and ignore size.
- Memory index is `sys_ad_in[log2(MEM_WORDS)+1:2]`. Addresses are word-aligned; bits[1:0] are ignored.
- Block transfers start at the addressed word and increment, wrapping within the naturally aligned block of that length.
- State machine:
  - RECOVER: `e_ok_l`=1 for one cycle, then go to GRANT.
  - GRANT: `e_ok_l`=0. A command is accepted only when `p_valid_l`=0 and `e_ok_l` has been low for this cycle and the previous one. A read goes to RD_WAIT; a write goes to WR_DATA.
  - RD_WAIT: count `READ_LAT`-1 cycles, then go to RD_DATA.
  - RD_DATA: drive consecutive words with `e_valid_l`=0 and `ad_oe`=1. `sys_cmd_out` is 5'b11000 for non-final words and 5'b10000 for the final word. After the final word, go to RECOVER.
  - WR_DATA: expect `p_valid_l`=0 with bit4=1 every cycle. Store `sys_ad_in` at the current index. Leave on a "last" word and go to RECOVER.
- `e_ok_l` is 1 in every state except GRANT.
- The following are errors: a data command (bit4=1) in a command cycle; block size 11; `p_valid_l`=1 during WR_DATA; "last" received before the expected count; "next" on the expected final word.
- On any error: set `err`, abandon the transfer, and go to RECOVER. Memory writes already performed are kept.
- `p_valid_l`=0 in GRANT while the two-cycle grant condition is not yet met is ignored. It is not an error.

## Timing
- Reset values: `e_ok_l`=1, `e_valid_l`=1, `ad_oe`=0, `sys_ad_out`=0, `sys_cmd_out`=0, `err`=0. State is RECOVER.
- `reset` asserted mid-transfer aborts immediately. Memory contents are not cleared.
- Earliest command acceptance is 2 cycles after GRANT entry.
- For a command sampled at edge N, the first read data is registered out at edge N+`READ_LAT`. Subsequent words follow back-to-back with no gaps.
- Write data is sampled every cycle starting at edge N+1.
- `ad_oe` is high exactly on the cycles where `e_valid_l`=0.
- After the last data cycle: one RECOVER cycle, then GRANT. The next command can be accepted no earlier than 3 cycles after the last data cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- A shared package `mbus_pkg` holds:
  - The command bit positions, size encodings, and data-command constants NEXT=5'b11000 and LAST=5'b10000.
  - The state enum.
  - A function mapping size to word count.
  The mbus monitor and the processor-side driver also use this package.
- One sub-module, `mbus_mem`: a synchronous-write, registered-read word memory of depth `MEM_WORDS`.

## Test plan
- Write word 0x100 = 0xDEADBEEF, then read word 0x100. Required: one data cycle with `e_valid_l`=0, `sys_cmd_out`=10000, and data DEADBEEF, arriving `READ_LAT` cycles after the read command.
- Write block, size 01, address 0x208, data 1,2,3,4; then read block, size 01, address 0x200. Required: data 3,4,1,2 in that order with cmd 11000,11000,11000,10000.
- `p_valid_l` low in the first GRANT cycle after reset. Required: no acceptance; the command is accepted on the second GRANT cycle.
- Write block, size 00, where the processor marks the first word "last". Required: `err`=1, RECOVER follows, and `e_ok_l`=0 two cycles later.
- Command cycle with `sys_cmd_in`=5'b10000, or block size 11. Required: `err`=1 and no data phase.
- `reset` pulsed during RD_DATA of an 8-word read. Required: all outputs return to their reset values on the next edge, and memory still returns the previously written data afterwards.
